// File: rtl/instruction_loader.sv
// -----------------------------------------------------------------------------
// instruction_loader
//
// Assembles little-endian bytes from a serial receiver into B-bit instruction
// words and writes them into instruction memory. A session starts on i_start,
// rewinds the memory write pointer, and ends either on the HALT instruction
// (which is still written) or when the memory is full.
//
// Ports
//   i_clk       clock, all state updates on the rising edge
//   i_reset     synchronous active-high reset
//   i_start     begin a program-load session (honoured in IDLE and DONE)
//   i_rx_data   received byte
//   i_rx_done   one-cycle strobe, i_rx_data valid
//   o_write     one-cycle write strobe to instruction memory
//   o_data      assembled instruction, held between writes
//   o_ptr_rst   one-cycle pulse rewinding the memory write pointer
//   o_count     words written in the current session
//   o_busy      high while loading
//   o_done      high once the session has ended
//   o_full_err  session ended because memory filled, not because of HALT
// -----------------------------------------------------------------------------
module instruction_loader #(
  parameter int            B    = 32,
  parameter int            W    = 10,
  parameter logic [B-1:0]  HALT = 32'hFFFFFFFF
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_start,
  input  logic [7:0]   i_rx_data,
  input  logic         i_rx_done,
  output logic         o_write,
  output logic [B-1:0] o_data,
  output logic         o_ptr_rst,
  output logic [W:0]   o_count,
  output logic         o_busy,
  output logic         o_done,
  output logic         o_full_err
);

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  // Word count at which memory is full (2**W).
  localparam logic [W:0] CAP = {1'b1, {W{1'b0}}};

  state_t       state;
  logic [1:0]   byte_idx;
  logic [B-9:0] assembly;    // lower three bytes of the word in progress
  logic [B-1:0] word;
  logic [W:0]   count_next;

  // The final byte completes the word directly from the input, so the write
  // can be issued on the same edge that captures it.
  assign word       = {i_rx_data, assembly};
  assign count_next = o_count + 1'b1;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state      <= IDLE;
      byte_idx   <= 2'd0;
      assembly   <= '0;
      o_write    <= 1'b0;
      o_data     <= '0;
      o_ptr_rst  <= 1'b0;
      o_count    <= '0;
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
      o_full_err <= 1'b0;
    end else begin
      o_write   <= 1'b0;
      o_ptr_rst <= 1'b0;
      case (state)
        IDLE, DONE: begin
          // A byte arriving alongside i_start is dropped: rx is not looked at here.
          if (i_start) begin
            state      <= LOAD;
            byte_idx   <= 2'd0;
            o_count    <= '0;
            o_full_err <= 1'b0;
            o_ptr_rst  <= 1'b1;
            o_busy     <= 1'b1;
            o_done     <= 1'b0;
          end
        end
        LOAD: begin
          if (i_rx_done) begin
            byte_idx <= byte_idx + 2'd1;
            case (byte_idx)
              2'd0: assembly[7:0]   <= i_rx_data;
              2'd1: assembly[15:8]  <= i_rx_data;
              2'd2: assembly[23:16] <= i_rx_data;
              default: begin
                o_write <= 1'b1;
                o_data  <= word;
                o_count <= count_next;
                // HALT is checked first so it wins when it is also the
                // capacity-filling word.
                if (word == HALT) begin
                  state      <= DONE;
                  o_busy     <= 1'b0;
                  o_done     <= 1'b1;
                  o_full_err <= 1'b0;
                end else if (count_next == CAP) begin
                  state      <= DONE;
                  o_busy     <= 1'b0;
                  o_done     <= 1'b1;
                  o_full_err <= 1'b1;
                end
              end
            endcase
          end
        end
        default: begin
          state  <= IDLE;
          o_busy <= 1'b0;
          o_done <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_loader.sv
// -----------------------------------------------------------------------------
// tb_instruction_loader
//
// Directed bench for instruction_loader. Two instances share the stimulus:
// u_big uses the default W=10, u_small uses W=2 (capacity 4 words) for the
// memory-full cases. Outputs are sampled 1 time unit after the rising edge.
// -----------------------------------------------------------------------------
module tb_instruction_loader;

  logic        clk;
  logic        reset;
  logic        start;
  logic [7:0]  rx_data;
  logic        rx_done;

  logic        write_b, ptr_b, busy_b, done_b, ferr_b;
  logic [31:0] data_b;
  logic [10:0] count_b;

  logic        write_s, ptr_s, busy_s, done_s, ferr_s;
  logic [31:0] data_s;
  logic [2:0]  count_s;

  int n_cmp = 0;
  int n_err = 0;

  instruction_loader #(.B(32), .W(10), .HALT(32'hFFFFFFFF)) u_big (
    .i_clk(clk), .i_reset(reset), .i_start(start),
    .i_rx_data(rx_data), .i_rx_done(rx_done),
    .o_write(write_b), .o_data(data_b), .o_ptr_rst(ptr_b),
    .o_count(count_b), .o_busy(busy_b), .o_done(done_b),
    .o_full_err(ferr_b)
  );

  instruction_loader #(.B(32), .W(2), .HALT(32'hFFFFFFFF)) u_small (
    .i_clk(clk), .i_reset(reset), .i_start(start),
    .i_rx_data(rx_data), .i_rx_done(rx_done),
    .o_write(write_s), .o_data(data_s), .o_ptr_rst(ptr_s),
    .o_count(count_s), .o_busy(busy_s), .o_done(done_s),
    .o_full_err(ferr_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    assert (got === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Present one byte for one cycle; returns just after the capturing edge.
  task automatic send_byte(input logic [7:0] b);
    rx_data = b;
    rx_done = 1'b1;
    tick();
    rx_done = 1'b0;
  endtask

  // Send the first three bytes of a little-endian word, checking no write.
  task automatic send_head(input logic [31:0] w, input string tag);
    send_byte(w[7:0]);
    check({tag, "_nowr0"}, 64'(write_b), 64'd0);
    send_byte(w[15:8]);
    check({tag, "_nowr1"}, 64'(write_b), 64'd0);
    send_byte(w[23:16]);
    check({tag, "_nowr2"}, 64'(write_b), 64'd0);
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    reset   = 1'b1;
    start   = 1'b0;
    rx_data = 8'h00;
    rx_done = 1'b0;
    tick();
    tick();

    // Reset state
    check("rst_write",  64'(write_b), 64'd0);
    check("rst_ptr",    64'(ptr_b),   64'd0);
    check("rst_busy",   64'(busy_b),  64'd0);
    check("rst_done",   64'(done_b),  64'd0);
    check("rst_ferr",   64'(ferr_b),  64'd0);
    check("rst_data",   64'(data_b),  64'd0);
    check("rst_count",  64'(count_b), 64'd0);
    reset = 1'b0;
    tick();

    // rx_done in IDLE is ignored
    send_byte(8'hAA);
    check("idle_rx_write", 64'(write_b), 64'd0);
    check("idle_rx_busy",  64'(busy_b),  64'd0);

    // start together with rx_done: byte dropped
    start   = 1'b1;
    rx_data = 8'hBB;
    rx_done = 1'b1;
    tick();
    start   = 1'b0;
    rx_done = 1'b0;
    check("start_ptr",   64'(ptr_b),   64'd1);
    check("start_busy",  64'(busy_b),  64'd1);
    check("start_write", 64'(write_b), 64'd0);
    check("start_count", 64'(count_b), 64'd0);
    tick();
    check("start_ptr_1cyc", 64'(ptr_b), 64'd0);

    // First word 0x00100013; 0x13 landing in bits 7:0 shows index stayed 0
    send_head(32'h00100013, "w1");
    send_byte(8'h00);
    check("w1_write", 64'(write_b), 64'd1);
    check("w1_data",  64'(data_b),  64'h00100013);
    check("w1_count", 64'(count_b), 64'd1);
    check("w1_busy",  64'(busy_b),  64'd1);
    check("w1_ptr",   64'(ptr_b),   64'd0);
    tick();
    check("w1_write_1cyc", 64'(write_b), 64'd0);
    check("w1_data_hold",  64'(data_b),  64'h00100013);

    // Second word, then HALT
    send_head(32'h11223344, "w2");
    send_byte(8'h11);
    check("w2_data",  64'(data_b),  64'h11223344);
    check("w2_count", 64'(count_b), 64'd2);
    send_head(32'hFFFFFFFF, "halt");
    send_byte(8'hFF);
    check("halt_write", 64'(write_b), 64'd1);
    check("halt_data",  64'(data_b),  64'hFFFFFFFF);
    check("halt_done",  64'(done_b),  64'd1);
    check("halt_busy",  64'(busy_b),  64'd0);
    check("halt_count", 64'(count_b), 64'd3);
    check("halt_ferr",  64'(ferr_b),  64'd0);
    check("halt_small_ferr", 64'(ferr_s), 64'd0);

    // Bytes in DONE are ignored; count holds
    tick();
    send_byte(8'h01);
    send_byte(8'h02);
    send_byte(8'h03);
    send_byte(8'h04);
    check("done_rx_write", 64'(write_b), 64'd0);
    check("done_count",    64'(count_b), 64'd3);
    check("done_data",     64'(data_b),  64'hFFFFFFFF);

    // Restart from DONE
    do_start();
    check("restart_ptr",   64'(ptr_b),   64'd1);
    check("restart_count", 64'(count_b), 64'd0);
    check("restart_ferr",  64'(ferr_b),  64'd0);
    check("restart_done",  64'(done_b),  64'd0);
    check("restart_busy",  64'(busy_b),  64'd1);
    tick();
    check("restart_ptr_1cyc", 64'(ptr_b), 64'd0);

    // Fill the W=2 instance with four non-HALT words
    for (int i = 1; i <= 4; i++) begin
      send_head(32'h0 + i, "fill");
      send_byte(8'h00);
      check("fill_write_s", 64'(write_s), 64'd1);
      check("fill_count_s", 64'(count_s), 64'(i));
    end
    check("full_done_s",  64'(done_s),  64'd1);
    check("full_ferr_s",  64'(ferr_s),  64'd1);
    check("full_data_s",  64'(data_s),  64'h00000004);
    check("full_busy_b",  64'(busy_b),  64'd1);
    check("full_count_b", 64'(count_b), 64'd4);

    // A further word: none from the full instance, the big one keeps loading
    send_head(32'h0A0B0C0D, "post");
    send_byte(8'h0A);
    check("post_write_s", 64'(write_s), 64'd0);
    check("post_count_s", 64'(count_s), 64'd4);
    check("post_ferr_s",  64'(ferr_s),  64'd1);
    check("post_write_b", 64'(write_b), 64'd1);
    check("post_count_b", 64'(count_b), 64'd5);
    check("post_data_b",  64'(data_b),  64'h0A0B0C0D);

    // HALT as the capacity-filling word: HALT wins
    do_start();
    tick();
    for (int i = 1; i <= 3; i++) begin
      send_head(32'h00000100 + i, "pre");
      send_byte(8'h00);
    end
    send_head(32'hFFFFFFFF, "halt_cap");
    send_byte(8'hFF);
    check("haltcap_done_s",  64'(done_s),  64'd1);
    check("haltcap_ferr_s",  64'(ferr_s),  64'd0);
    check("haltcap_count_s", 64'(count_s), 64'd4);

    // Partial word discarded by reset
    tick();
    do_start();
    tick();
    send_byte(8'hAA);
    send_byte(8'hBB);
    reset = 1'b1;
    start = 1'b1;
    tick();
    reset = 1'b0;
    start = 1'b0;
    check("rstload_busy",  64'(busy_b),  64'd0);
    check("rstload_ptr",   64'(ptr_b),   64'd0);
    check("rstload_count", 64'(count_b), 64'd0);
    check("rstload_data",  64'(data_b),  64'd0);
    do_start();
    tick();
    send_head(32'h04030201, "afterrst");
    send_byte(8'h04);
    check("afterrst_write", 64'(write_b), 64'd1);
    check("afterrst_data",  64'(data_b),  64'h04030201);
    check("afterrst_count", 64'(count_b), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/instruction_loader.md
INSTRUCTION_LOADER -- requirements
Module: instruction_loader

Interface
REQ-001 The block SHALL have parameter B, default 32, meaning instruction width in bits, fixed at 4 bytes.
REQ-002 The block SHALL have parameter W, default 10, meaning instruction-memory address bits, giving a capacity of 2**W words.
REQ-003 The block SHALL have parameter HALT, default 32'hFFFFFFFF, meaning the end-of-program instruction code.
REQ-004 The block SHALL have port i_clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port i_reset, input, 1 bit: reset, synchronous and active-high.
REQ-006 The block SHALL have port i_start, input, 1 bit: begin a program-load session.
REQ-007 The block SHALL have port i_rx_data, input, 8 bits: received byte from the serial receiver.
REQ-008 The block SHALL have port i_rx_done, input, 1 bit: one-cycle strobe, i_rx_data valid.
REQ-009 The block SHALL have port o_write, output, 1 bit: one-cycle write strobe to instruction memory.
REQ-010 The block SHALL have port o_data, output, B bits: assembled instruction to write.
REQ-011 The block SHALL have port o_ptr_rst, output, 1 bit: one-cycle pulse that rewinds the memory write pointer.
REQ-012 The block SHALL have port o_count, output, W+1 bits: words written in the current session.
REQ-013 The block SHALL have port o_busy, output, 1 bit: high while in LOAD.
REQ-014 The block SHALL have port o_done, output, 1 bit: high while in DONE.
REQ-015 The block SHALL have port o_full_err, output, 1 bit: the session ended by capacity, not by HALT.

Function
REQ-016 The block SHALL implement FSM states IDLE, LOAD and DONE.
REQ-017 In IDLE or DONE, i_start SHALL move the FSM to LOAD at the next edge, clear the byte index, o_count and o_full_err, and pulse o_ptr_rst high for exactly that next cycle.
REQ-018 In LOAD, each i_rx_done SHALL place i_rx_data into the assembly register at byte index k (k=0 is bits 7:0, little-endian) and increment k modulo 4.
REQ-019 When the byte with k=3 is captured at edge n, o_write SHALL be high during cycle n+1 only, with o_data holding the full word and o_count incremented by 1 in that same cycle.
REQ-020 o_data SHALL hold its last value when o_write is low.
REQ-021 There SHALL be exactly one o_write pulse per 4 accepted bytes, and never in a cycle where o_ptr_rst is high.
REQ-022 If the completed word equals HALT, the word SHALL still be written, and the FSM SHALL enter DONE in cycle n+1 with o_full_err=0.
REQ-023 If the write makes o_count equal 2**W and the word is not HALT, the FSM SHALL enter DONE in cycle n+1 with o_full_err=1.
REQ-024 If the final word is both HALT and the capacity-filling word, HALT SHALL take precedence (o_full_err=0).
REQ-025 i_rx_done SHALL be ignored in IDLE and DONE, and i_start SHALL be ignored in LOAD.
REQ-026 If i_start and i_rx_done are high in the same cycle while in IDLE or DONE, the byte SHALL be dropped.
REQ-027 o_busy and o_done SHALL be registered state decodes with no combinational path from inputs.
REQ-028 In DONE, o_count and o_full_err SHALL hold until the next i_start or reset.

Reset
REQ-029 While i_reset is high at a rising edge, the FSM SHALL go to IDLE, the byte index and o_count SHALL be 0, and o_write, o_ptr_rst, o_busy, o_done, o_full_err and o_data SHALL all be 0.
REQ-030 Reset during LOAD SHALL discard any partially assembled word, and no write SHALL occur from the partial word.
REQ-031 Reset SHALL take priority over i_start and i_rx_done in the same cycle.

Verification
REQ-032 The bench SHALL cover: i_start, then bytes 0x13,0x00,0x10,0x00 -> single o_write cycle after the 4th byte with o_data=32'h00100013 and o_count=1; o_busy=1.
REQ-033 The bench SHALL cover: two words followed by bytes FF,FF,FF,FF -> 3 writes, the 3rd with o_data=32'hFFFFFFFF; o_done=1 in the same cycle; o_count=3; o_full_err=0.
REQ-034 The bench SHALL cover: W=2 with 4 non-HALT words -> o_done=1 and o_full_err=1 after the 4th write; a subsequent byte produces no write.
REQ-035 The bench SHALL cover: 2 bytes, then i_reset, then i_start, then 4 bytes -> the written word contains only the post-reset bytes; o_count=1.
REQ-036 The bench SHALL cover: in DONE, i_start -> o_ptr_rst for one cycle, o_count=0, o_full_err cleared, and loading resumes.
REQ-037 The bench SHALL cover: i_rx_done in IDLE, and i_start simultaneous with i_rx_done -> no o_write and the byte index stays at 0.
